// File: rtl/regfile_write_arbiter.sv
// Purpose: arbitrates two register-file write requesters (round-robin) and runs a zero-sweep over addresses 1..N-1.
// Latency: one cycle from a granted request (or sweep step) to the registered rf write outputs.
// Backpressure: one write per two cycles; requests are not acked while a write or sweep is in progress.
//
// Ports:
//   clock_reg, reset                 rising-edge clock, synchronous active-high reset
//   req_a/addr_a/data_a, ack_a       requester A write request and one-cycle accept pulse
//   req_b/addr_b/data_b, ack_b       requester B, same as A
//   clear_req, clear_done, busy      sweep start, one-cycle sweep-end pulse, not-idle indicator
//   rf_write_enable/_address/_data   register-file write port (address 0 is never enabled)
//   last_grant                       0 = A most recently granted, 1 = B
module regfile_write_arbiter #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 3
) (
    input  logic              clock_reg,
    input  logic              reset,
    input  logic              req_a,
    input  logic [ADDR_W-1:0] addr_a,
    input  logic [DATA_W-1:0] data_a,
    output logic              ack_a,
    input  logic              req_b,
    input  logic [ADDR_W-1:0] addr_b,
    input  logic [DATA_W-1:0] data_b,
    output logic              ack_b,
    input  logic              clear_req,
    output logic              clear_done,
    output logic              busy,
    output logic              rf_write_enable,
    output logic [ADDR_W-1:0] rf_write_address,
    output logic [DATA_W-1:0] rf_write_data,
    output logic              last_grant
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        CLEAR = 2'd2
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_ADDR  = '1;
    localparam logic [ADDR_W-1:0] FIRST_ADDR = ADDR_W'(1);

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   sweep_q, sweep_d;
    logic                ack_a_q, ack_a_d;
    logic                ack_b_q, ack_b_d;
    logic                clear_done_q, clear_done_d;
    logic                busy_q, busy_d;
    logic                we_q, we_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic                last_grant_q, last_grant_d;

    // B wins when it is the only requester, or on a tie when A was granted last.
    logic grant_b;
    assign grant_b = req_b && (!req_a || !last_grant_q);

    // State register plus registered outputs.
    always_ff @(posedge clock_reg) begin
        if (reset) begin
            state_q      <= IDLE;
            sweep_q      <= '0;
            ack_a_q      <= 1'b0;
            ack_b_q      <= 1'b0;
            clear_done_q <= 1'b0;
            busy_q       <= 1'b0;
            we_q         <= 1'b0;
            addr_q       <= '0;
            data_q       <= '0;
            last_grant_q <= 1'b1;
        end else begin
            state_q      <= state_d;
            sweep_q      <= sweep_d;
            ack_a_q      <= ack_a_d;
            ack_b_q      <= ack_b_d;
            clear_done_q <= clear_done_d;
            busy_q       <= busy_d;
            we_q         <= we_d;
            addr_q       <= addr_d;
            data_q       <= data_d;
            last_grant_q <= last_grant_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (clear_req)
                    state_d = CLEAR;
                else if (req_a || req_b)
                    state_d = WRITE;
            end
            WRITE:   state_d = IDLE;
            CLEAR: begin
                if (sweep_q == LAST_ADDR)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Output logic: computes the values the output registers take on the next edge.
    always_comb begin
        ack_a_d      = 1'b0;
        ack_b_d      = 1'b0;
        clear_done_d = 1'b0;
        we_d         = 1'b0;
        addr_d       = addr_q;
        data_d       = data_q;
        last_grant_d = last_grant_q;
        sweep_d      = sweep_q;
        busy_d       = (state_d != IDLE);
        case (state_q)
            IDLE: begin
                if (clear_req) begin
                    sweep_d = FIRST_ADDR;
                    we_d    = 1'b1;
                    addr_d  = FIRST_ADDR;
                    data_d  = '0;
                end else if (req_a || req_b) begin
                    if (grant_b) begin
                        ack_b_d      = 1'b1;
                        addr_d       = addr_b;
                        data_d       = data_b;
                        last_grant_d = 1'b1;
                    end else begin
                        ack_a_d      = 1'b1;
                        addr_d       = addr_a;
                        data_d       = data_a;
                        last_grant_d = 1'b0;
                    end
                    // x0 is hard-wired zero: acknowledge but never write it.
                    we_d = (addr_d != '0);
                end
            end
            CLEAR: begin
                if (sweep_q == LAST_ADDR) begin
                    clear_done_d = 1'b1;
                    sweep_d      = '0;
                end else begin
                    sweep_d = sweep_q + FIRST_ADDR;
                    we_d    = 1'b1;
                    addr_d  = sweep_q + FIRST_ADDR;
                    data_d  = '0;
                end
            end
            default: ;
        endcase
    end

    assign ack_a            = ack_a_q;
    assign ack_b            = ack_b_q;
    assign clear_done       = clear_done_q;
    assign busy             = busy_q;
    assign rf_write_enable  = we_q;
    assign rf_write_address = addr_q;
    assign rf_write_data    = data_q;
    assign last_grant       = last_grant_q;

endmodule
